mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator that sits between the core's execute stage and the word-addressed data memory. It accepts RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW), drives the memory's address/write_data/write_enable port, and returns sign- or zero-extended load data. Sub-word stores use a read-modify-write sequence because the memory only writes whole words. Misaligned or illegal-width requests are rejected with an error response and never touch memory.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned or illegal funct3.
- mem_address  out  32  word-aligned address to memory ({addr[31:2],2'b00}).
- mem_write_data  out  32  full word to write.
- mem_write_enable  out  1  memory writes mem_write_data at next posedge.
- mem_read_data  in  32  combinational read of word at mem_address.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Handshake: request accepted on posedge where req_valid && req_ready; all req_* fields latched then. req_* ignored outside acceptance.
- Legality: loads accept funct3 000/001/010/100/101; stores accept 000/001/010 only. Halfword needs addr[0]=0; word needs addr[1:0]=00. Otherwise IDLE -> RESP with resp_err=1.
- Legal load: IDLE -> READ -> RESP. In READ, word sampled from mem_read_data into data register.
- SW: IDLE -> WRITE -> RESP; mem_write_data = req_wdata.
- SB/SH: IDLE -> READ -> WRITE -> RESP. READ captures old word; WRITE drives old word with lane(s) selected by addr[1:0] (byte) or addr[1] (half) replaced by req_wdata[7:0]/[15:0].
- Load extract: lane = word >> (8*addr[1:0]); B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Core must consume in that cycle (no backpressure).
- mem_write_enable high only in WRITE and only when rst=0.
- mem_address holds latched aligned address from acceptance until next acceptance.

## Timing
- Reset (rst high at posedge): state IDLE; req_ready=1 next cycle; resp_valid=0, resp_err=0, resp_rdata=0, mem_address=0, mem_write_data=0, mem_write_enable=0.
- Reset mid-operation: transaction discarded, no response; rst high during WRITE suppresses the write (gated combinationally).
- Latency counted from acceptance edge (cycle 0) to resp_valid high: error 1, load 2, SW 2, SB/SH 3 cycles.
- Throughput: next request acceptable the cycle after RESP (req_ready rises with return to IDLE).
- resp_rdata/resp_err are valid only while resp_valid=1; held until next RESP otherwise.
- Memory write for stores lands on the posedge ending WRITE; a load issued immediately after sees new data.

## Test plan
Bench memory preloaded: word0=0xDEADBEEF, word1=0x12345678, word2=0xABCDEF01, word3=0xFEDCBA98.
- LB addr 0x3 -> resp_rdata 0xFFFFFFDE; LBU addr 0x3 -> 0x000000DE; each resp_valid 2 cycles after accept.
- LH addr 0x2 -> 0xFFFFDEAD; LHU addr 0x4 -> 0x00005678; LW addr 0x8 -> 0xABCDEF01.
- SB addr 0x9 data 0x000000AA -> one write cycle, word2 becomes 0xABCDAA01, resp 3 cycles after accept; follow-up LW 0x8 returns 0xABCDAA01.
- SH addr 0xE data 0x00001234 -> word3 0x1234BA98; SW addr 0x0 data 0xCAFEF00D -> word0 0xCAFEF00D, resp 2 cycles after accept.
- LW addr 0x6, SH addr 0x1, SB funct3 100 -> resp_err=1 after 1 cycle, resp_rdata 0, mem_write_enable never asserted, memory unchanged.
- rst asserted in WRITE of an SB -> no write, no resp_valid, all outputs at reset values, req_ready=1 the cycle after.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and a word-addressed data memory.
// Sub-word stores are done as read-modify-write; illegal requests get an error response.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        mem_we_q, mem_we_d;

    function automatic logic is_legal(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (lo[0] == 1'b0);
            3'b010:  ok = (lo == 2'b00);
            3'b100:  ok = !wr;
            3'b101:  ok = !wr && (lo[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] lo);
        logic [31:0] lane;
        logic [31:0] res;
        lane = word >> {lo, 3'b000};
        case (f3)
            3'b000:  res = {{24{lane[7]}}, lane[7:0]};
            3'b001:  res = {{16{lane[15]}}, lane[15:0]};
            3'b010:  res = lane;
            3'b100:  res = {24'h000000, lane[7:0]};
            3'b101:  res = {16'h0000, lane[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replicate the store data across all lanes, then let the lane mask pick the target bytes.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [15:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] mask;
        logic [31:0] data;
        case (f3)
            3'b000: begin
                mask = 32'h0000_00FF << {lo, 3'b000};
                data = {4{wd[7:0]}};
            end
            3'b001: begin
                mask = 32'h0000_FFFF << {lo[1], 4'b0000};
                data = {2{wd}};
            end
            default: begin
                mask = 32'h0000_0000;
                data = 32'h0000_0000;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    // Next-state and datapath register updates.
    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        funct3_d         = funct3_q;
        addr_lo_d        = addr_lo_q;
        wdata_d          = wdata_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        resp_rdata_d     = resp_rdata_q;
        resp_err_d       = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d       = req_write;
                    funct3_d      = req_funct3;
                    addr_lo_d     = req_addr[1:0];
                    wdata_d       = req_wdata[15:0];
                    mem_address_d = {req_addr[31:2], 2'b00};
                    if (!is_legal(req_write, req_funct3, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end else if (req_write && (req_funct3 == 3'b010)) begin
                        state_d          = WRITE;
                        mem_write_data_d = req_wdata;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (write_q) begin
                    mem_write_data_d = store_merge(mem_read_data, wdata_q, funct3_q, addr_lo_q);
                    state_d          = WRITE;
                end else begin
                    resp_rdata_d = load_extract(mem_read_data, funct3_q, addr_lo_q);
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end
            end
            WRITE: begin
                resp_rdata_d = 32'h0000_0000;
                resp_err_d   = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        mem_we_d     = (state_d == WRITE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
            wdata_q          <= 16'h0000;
            mem_address_q    <= 32'h0000_0000;
            mem_write_data_q <= 32'h0000_0000;
            resp_rdata_q     <= 32'h0000_0000;
            resp_err_q       <= 1'b0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            mem_we_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            funct3_q         <= funct3_d;
            addr_lo_q        <= addr_lo_d;
            wdata_q          <= wdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            mem_we_q         <= mem_we_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_err         = resp_err_q;
    assign mem_address      = mem_address_q;
    assign mem_write_data   = mem_write_data_q;
    // A reset arriving during WRITE must kill the write before the edge it would land on.
    assign mem_write_enable = mem_we_q && !rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small 4-word memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:3];
    logic [1:0]  mem_idx;
    int          write_count;
    int          checks;
    int          errors;

    mem_access_unit dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_idx       = mem_address[3:2];
    assign mem_read_data = mem[mem_idx];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_idx] <= mem_write_data;
            write_count  <= write_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge, measure latency, check response; returns at a negedge.
    task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_writes);
        int lat;
        int wc0;
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        wc0        = write_count;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5A5A_5A5A;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat = lat + 1;
            if (resp_valid) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        chk({tag, "_writes"}, 32'(write_count - wc0), 32'(exp_writes));
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        write_count = 0;
        mem[0] = 32'hDEAD_BEEF;
        mem[1] = 32'h1234_5678;
        mem[2] = 32'hABCD_EF01;
        mem[3] = 32'hFEDC_BA98;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0000;
        req_wdata  = 32'h0000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0000_0000);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_addr", mem_address, 32'h0000_0000);
        chk("rst_wdata", mem_write_data, 32'h0000_0000);
        chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req("lb3",  1'b0, 3'b000, 32'h3, 32'h0, 2, 32'hFFFF_FFDE, 1'b0, 0);
        do_req("lbu3", 1'b0, 3'b100, 32'h3, 32'h0, 2, 32'h0000_00DE, 1'b0, 0);
        do_req("lh2",  1'b0, 3'b001, 32'h2, 32'h0, 2, 32'hFFFF_DEAD, 1'b0, 0);
        do_req("lhu4", 1'b0, 3'b101, 32'h4, 32'h0, 2, 32'h0000_5678, 1'b0, 0);
        do_req("lw8",  1'b0, 3'b010, 32'h8, 32'h0, 2, 32'hABCD_EF01, 1'b0, 0);
        do_req("sb9",  1'b1, 3'b000, 32'h9, 32'h0000_00AA, 3, 32'h0, 1'b0, 1);
        chk("sb9_mem", mem[2], 32'hABCD_AA01);
        do_req("lw8b", 1'b0, 3'b010, 32'h8, 32'h0, 2, 32'hABCD_AA01, 1'b0, 0);
        do_req("she",  1'b1, 3'b001, 32'hE, 32'h0000_1234, 3, 32'h0, 1'b0, 1);
        chk("she_mem", mem[3], 32'h1234_BA98);
        chk("she_addr", mem_address, 32'h0000_000C);
        do_req("sw0",  1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 1);
        chk("sw0_mem", mem[0], 32'hCAFE_F00D);
        do_req("lw0",  1'b0, 3'b010, 32'h0, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 0);
        do_req("elw6", 1'b0, 3'b010, 32'h6, 32'h0, 1, 32'h0, 1'b1, 0);
        do_req("esh1", 1'b1, 3'b001, 32'h1, 32'h0000_FFFF, 1, 32'h0, 1'b1, 0);
        do_req("esbu", 1'b1, 3'b100, 32'h0, 32'h0000_00FF, 1, 32'h0, 1'b1, 0);
        do_req("elf3", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0);
        chk("err_mem0", mem[0], 32'hCAFE_F00D);
        chk("err_mem1", mem[1], 32'h1234_5678);
        chk("err_mem2", mem[2], 32'hABCD_AA01);
        chk("err_mem3", mem[3], 32'h1234_BA98);

        // SB interrupted by reset while in WRITE
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0000;
        req_wdata  = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rw_in_write", {31'd0, mem_write_enable}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_we_gated", {31'd0, mem_write_enable}, 32'd0);
        @(negedge clk);
        chk("rw_valid", {31'd0, resp_valid}, 32'd0);
        chk("rw_ready", {31'd0, req_ready}, 32'd1);
        chk("rw_rdata", resp_rdata, 32'h0000_0000);
        chk("rw_err", {31'd0, resp_err}, 32'd0);
        chk("rw_addr", mem_address, 32'h0000_0000);
        chk("rw_wdata", mem_write_data, 32'h0000_0000);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_mem0", mem[0], 32'hCAFE_F00D);
        chk("rw_ready2", {31'd0, req_ready}, 32'd1);
        chk("rw_valid2", {31'd0, resp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
